coreuart_tx_serializer: RTL and testbench
=========================================

# coreuart_tx_serializer

Transmit stage of CoreUART that drains the 256x8 TX FIFO and drives the serial TX line. Holds the FIFO read strobe for exactly one cycle per character and captures the registered FIFO output after the fixed FIFO read latency. Shifts the character out LSB first as start, data, optional parity and stop bits, timed by the 16x baud enable. Sits directly downstream of the TX FIFO, and its TX output goes to the pad.

## Interface
- FIFO_LATENCY, 2: cycles from the FIFO_RDB low cycle to valid FIFO_DO (FIFO core plus output register).
- OVERSAMPLE, 16: BAUD_TICK pulses per serial bit.

- CLK  in  1  system clock; the FIFO control runs on this clock, not the baud clock.
- RESET_N  in  1  asynchronous, active-low reset.
- BAUD_TICK  in  1  single-cycle enable at 16x the baud rate.
- BIT8  in  1  1: 8 data bits; 0: 7 data bits.
- PARITY_EN  in  1  1: insert a parity bit (see Configuration).
- ODD_N_EVEN  in  1  1: odd parity; 0: even parity.
- FIFO_EMPTY  in  1  TX FIFO empty flag.
- FIFO_DO  in  8  registered TX FIFO read data.
- FIFO_RDB  out  1  active-low FIFO read strobe.
- TX  out  1  serial output; idles high.
- TX_BUSY  out  1  high from strobe issue to end of the stop bit.

## Operation
- States: IDLE → FETCH → WAIT → START → DATA → PARITY → STOP → IDLE.
- **IDLE**: when FIFO_EMPTY is 0, drive FIFO_RDB low for one cycle, then go to FETCH.
- **FETCH/WAIT**: count FIFO_LATENCY cycles from the strobe cycle. On the last count, load FIFO_DO into the shift register and go to START.
- **START**: TX = 0 for OVERSAMPLE ticks.
- **DATA**: TX = shift[0] for each bit, shift right once per bit. Send 8 bits, or 7 when BIT8 = 0 (bit 7 is ignored).
- **PARITY**: entered only when the parity feature is compiled in and PARITY_EN = 1. TX = XOR of the sent data bits, XOR ODD_N_EVEN.
- **STOP**: TX = 1 for one bit, then go to IDLE.
- Tick counter: 4 bits, cleared on entry to START. A bit ends on the OVERSAMPLE-th BAUD_TICK.
- Bit counter: 3 bits, last bit = 7 − !BIT8.
- BIT8, PARITY_EN and ODD_N_EVEN are sampled at load and held for the whole frame. Changes mid-frame have no effect on the current frame.
- FIFO_EMPTY is ignored outside IDLE. Exactly one read is issued per frame, so there is no overrun and no double read.
- FIFO_RDB is never low outside the IDLE→FETCH transition cycle.

## Timing
- Reset values: TX = 1, FIFO_RDB = 1, TX_BUSY = 0, state = IDLE, all counters 0.
- RESET_N low mid-frame: TX goes to 1 asynchronously. The character is lost and is not re-read.
- FIFO_EMPTY falling at cycle n: FIFO_RDB is low in cycle n+1 (registered output), and the START bit drives TX from cycle n+1+FIFO_LATENCY.
- Each bit lasts OVERSAMPLE BAUD_TICKs. With BAUD_TICK tied high, a bit is 16 cycles and an 8N1 frame is 160 cycles.
- Back-to-back frames: the next strobe is issued one cycle after STOP completes if FIFO_EMPTY = 0. The inter-frame gap is 1+FIFO_LATENCY cycles of idle high.
- TX and FIFO_RDB come directly from flops (glitch-free).

## Configuration
- Macro: COREUART_TX_PARITY_EN.
- **Defined**: the PARITY state and parity logic are built, and PARITY_EN and ODD_N_EVEN behave as above.
- **Undefined**: the PARITY state is removed and the PARITY_EN and ODD_N_EVEN ports remain but are ignored. Frames always go DATA → STOP.

## Structure
- Package coreuart_pkg holds:
  - tx state enum,
  - OVERSAMPLE_DEF = 16 and FIFO_LATENCY_DEF = 2,
  - bit-count width constant.
- Sub-module coreuart_tx_parity: running XOR accumulator, cleared at load and updated per data bit, plus odd/even select. Instantiated only under COREUART_TX_PARITY_EN.

## Test plan
All cases use BAUD_TICK tied high unless stated otherwise.

- **Reset**: RESET_N low → TX = 1, FIFO_RDB = 1, TX_BUSY = 0. Release with FIFO_EMPTY = 1 → no strobe for 1000 cycles.
- **8N1**: FIFO holds 0x55 → one FIFO_RDB low pulse. TX = 0,1,0,1,0,1,0,1,0,1, each held 16 cycles. Start bit begins 3 cycles after the FIFO_EMPTY fall.
- **Parity 8E1/8O1** (macro defined): 0xA5 → parity bit 0 with even, 1 with odd, and frame length 176 cycles. With the macro undefined, the same stimulus gives 160 cycles and no parity bit.
- **7-bit even**: BIT8 = 0, data 0xFF → seven 1 data bits, then parity bit 1, then stop.
- **Back-to-back**: FIFO holds 0x01, 0x80, 0xFF → exactly three strobes and three correct frames with 3-cycle idle gaps. TX_BUSY stays low only in the gaps.
- **Mid-frame reset**: RESET_N low during bit 4 → TX = 1 immediately. After release, the next FIFO entry is sent cleanly and the aborted byte is not repeated.
- **Sparse tick**: BAUD_TICK every 5th cycle → each bit lasts 80 cycles.

Source files
------------

// File: rtl/coreuart_tx_serializer_pkg.sv
// Shared state encoding and defaults for the CoreUART transmit path.
// Build macro COREUART_TX_PARITY_EN adds the PARITY state to the enum.
package coreuart_pkg;

   localparam int OVERSAMPLE_DEF   = 16;
   localparam int FIFO_LATENCY_DEF = 2;
   localparam int BIT_CNT_W        = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_START,
      ST_DATA,
`ifdef COREUART_TX_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } tx_state_e;

endpackage

// File: rtl/coreuart_tx_serializer_if.sv
// FIFO-side handshake, line configuration and serial output of the UART transmitter.
// The master drives FIFO status/data and configuration; the slave is the serializer.
interface coreuart_tx_serializer_if;

   logic       BAUD_TICK;
   logic       BIT8;
   logic       PARITY_EN;
   logic       ODD_N_EVEN;
   logic       FIFO_EMPTY;
   logic [7:0] FIFO_DO;
   logic       FIFO_RDB;
   logic       TX;
   logic       TX_BUSY;

   modport master (
      output BAUD_TICK, BIT8, PARITY_EN, ODD_N_EVEN, FIFO_EMPTY, FIFO_DO,
      input  FIFO_RDB, TX, TX_BUSY
   );

   modport slave (
      input  BAUD_TICK, BIT8, PARITY_EN, ODD_N_EVEN, FIFO_EMPTY, FIFO_DO,
      output FIFO_RDB, TX, TX_BUSY
   );

endinterface

// File: rtl/coreuart_tx_serializer_parity.sv
// Running XOR of the data bits of one frame, with odd/even selection on the output.
// Only instantiated when COREUART_TX_PARITY_EN is defined.
module coreuart_tx_parity (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic upd_i,
   input  logic bit_i,
   input  logic odd_i,
   output logic parity_o
);

   logic acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = 1'b0;
      end else if (upd_i) begin
         acc_d = acc_q ^ bit_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign parity_o = acc_q ^ odd_i;

endmodule

// File: rtl/coreuart_tx_serializer.sv
// CoreUART transmit serializer: one FIFO read per frame, then start/data/[parity]/stop.
// Build macro COREUART_TX_PARITY_EN enables the parity bit; otherwise PARITY_EN/ODD_N_EVEN are ignored.
module coreuart_tx_serializer
   import coreuart_pkg::*;
#(
   parameter int OVERSAMPLE   = OVERSAMPLE_DEF,
   parameter int FIFO_LATENCY = FIFO_LATENCY_DEF
) (
   input logic                     CLK,
   input logic                     RESET_N,
   coreuart_tx_serializer_if.slave bus
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int LAT_W  = $clog2(FIFO_LATENCY + 1);

   tx_state_e              state_q, state_d;
   logic [TICK_W-1:0]      tick_q, tick_d;
   logic [BIT_CNT_W-1:0]   bitc_q, bitc_d;
   logic [LAT_W-1:0]       lat_q, lat_d;
   logic [7:0]             shift_q, shift_d;
   logic                   bit8_q, bit8_d;
   logic                   tx_q, tx_d;
   logic                   rdb_q, rdb_d;
   logic                   busy_q, busy_d;
   logic                   bit_done;
   logic                   load;
   logic [BIT_CNT_W-1:0]   last_bit;

   assign bit_done = bus.BAUD_TICK && (tick_q == TICK_W'(OVERSAMPLE - 1));
   assign load     = ((state_q == ST_FETCH) || (state_q == ST_WAIT)) &&
                     (lat_q == LAT_W'(FIFO_LATENCY - 1));
   assign last_bit = bit8_q ? BIT_CNT_W'(7) : BIT_CNT_W'(6);

`ifdef COREUART_TX_PARITY_EN
   logic paren_q, paren_d;
   logic odd_q, odd_d;
   logic par_bit;
   logic par_upd;
   logic par_in;

   // Accumulate each data bit as it is launched onto the line.
   assign par_upd = bit_done &&
                    ((state_q == ST_START) || ((state_q == ST_DATA) && (bitc_q != last_bit)));
   assign par_in  = (state_q == ST_START) ? shift_q[0] : shift_q[1];

   coreuart_tx_parity u_parity (
      .clk_i    (CLK),
      .rst_n_i  (RESET_N),
      .clr_i    (load),
      .upd_i    (par_upd),
      .bit_i    (par_in),
      .odd_i    (odd_q),
      .parity_o (par_bit)
   );
`else
   logic unused_cfg;
   assign unused_cfg = bus.PARITY_EN ^ bus.ODD_N_EVEN;
`endif

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bitc_d  = bitc_q;
      lat_d   = lat_q;
      shift_d = shift_q;
      bit8_d  = bit8_q;
      tx_d    = tx_q;
      rdb_d   = 1'b1;
      busy_d  = busy_q;
`ifdef COREUART_TX_PARITY_EN
      paren_d = paren_q;
      odd_d   = odd_q;
`endif
      if (bus.BAUD_TICK && (state_q != ST_IDLE) && (state_q != ST_FETCH) && (state_q != ST_WAIT)) begin
         tick_d = bit_done ? '0 : tick_q + TICK_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (!bus.FIFO_EMPTY) begin
               rdb_d   = 1'b0;
               busy_d  = 1'b1;
               lat_d   = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH, ST_WAIT: begin
            if (load) begin
               state_d = ST_START;
               shift_d = bus.FIFO_DO;
               bit8_d  = bus.BIT8;
               tick_d  = '0;
               bitc_d  = '0;
               lat_d   = '0;
               tx_d    = 1'b0;
`ifdef COREUART_TX_PARITY_EN
               paren_d = bus.PARITY_EN;
               odd_d   = bus.ODD_N_EVEN;
`endif
            end else begin
               lat_d   = lat_q + LAT_W'(1);
               state_d = ST_WAIT;
            end
         end
         ST_START: begin
            if (bit_done) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bitc_q == last_bit) begin
                  bitc_d  = '0;
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`ifdef COREUART_TX_PARITY_EN
                  if (paren_q) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit;
                  end
`endif
               end else begin
                  bitc_d = bitc_q + BIT_CNT_W'(1);
                  tx_d   = shift_q[1];
               end
            end
         end
`ifdef COREUART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_done) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bit_done) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bitc_q  <= '0;
         lat_q   <= '0;
         bit8_q  <= 1'b0;
         tx_q    <= 1'b1;
         rdb_q   <= 1'b1;
         busy_q  <= 1'b0;
`ifdef COREUART_TX_PARITY_EN
         paren_q <= 1'b0;
         odd_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bitc_q  <= bitc_d;
         lat_q   <= lat_d;
         bit8_q  <= bit8_d;
         tx_q    <= tx_d;
         rdb_q   <= rdb_d;
         busy_q  <= busy_d;
`ifdef COREUART_TX_PARITY_EN
         paren_q <= paren_d;
         odd_q   <= odd_d;
`endif
      end
   end

   // Character data carries no reset; it is always loaded before use.
   always_ff @(posedge CLK) begin
      shift_q <= shift_d;
   end

   assign bus.TX       = tx_q;
   assign bus.FIFO_RDB = rdb_q;
   assign bus.TX_BUSY  = busy_q;

endmodule

// File: tb/tb_coreuart_tx_serializer.sv
// Bench for coreuart_tx_serializer: a queue-backed FIFO model, per-cycle traces of TX/FIFO_RDB/TX_BUSY,
// and a frame model built from the line rules (start, LSB-first data, optional parity, stop).
module tb_coreuart_tx_serializer;

   localparam int MAXC = 16384;
`ifdef COREUART_TX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   coreuart_tx_serializer_if bus();

   coreuart_tx_serializer dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   fall_cyc = -1;
   int   checks = 0;
   int   errors = 0;
   bit   sparse = 1'b0;
   logic tx_tr   [MAXC];
   logic rdb_tr  [MAXC];
   logic busy_tr [MAXC];
   logic [7:0] fifo_q[$];
   logic exp_bits[$];

   // Per-cycle trace, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (cyc < MAXC) begin
            tx_tr[cyc]   = bus.TX;
            rdb_tr[cyc]  = bus.FIFO_RDB;
            busy_tr[cyc] = bus.TX_BUSY;
         end
      end
   end

   // FIFO model: a strobe seen in one cycle presents the popped byte for the next capture edge.
   initial begin
      logic was_empty;
      bus.FIFO_EMPTY = 1'b1;
      bus.FIFO_DO    = 8'h00;
      bus.BAUD_TICK  = 1'b1;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         if (cyc - 1 < MAXC && rdb_tr[cyc-1] === 1'b0 && fifo_q.size() > 0)
            bus.FIFO_DO = fifo_q.pop_front();
         else
            bus.FIFO_DO = 8'($urandom);
         was_empty      = bus.FIFO_EMPTY;
         bus.FIFO_EMPTY = (fifo_q.size() == 0);
         if (was_empty && !bus.FIFO_EMPTY) fall_cyc = cyc;
         bus.BAUD_TICK = sparse ? (cyc % 5 == 0) : 1'b1;
      end
   end

   function automatic void model_frame(input logic [7:0] d, input bit b8, input bit pe, input bit odd);
      int nb;
      logic p;
      nb = b8 ? 8 : 7;
      p  = odd;
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         exp_bits.push_back(d[i]);
         p = p ^ d[i];
      end
      if (PAR_BUILT && pe) exp_bits.push_back(p);
      exp_bits.push_back(1'b1);
   endfunction

   // Index of the first model bit whose cycles disagree with the trace, or -1.
   function automatic int frame_err(input int start, input int bitlen, input int first);
      for (int k = first; k < exp_bits.size(); k++)
         for (int c = start + k * bitlen; c < start + (k + 1) * bitlen; c++)
            if (c < 0 || c >= MAXC || tx_tr[c] !== exp_bits[k]) return k;
      return -1;
   endfunction

   function automatic int find_tx(input int from, input int to, input logic v);
      for (int c = from; c < to && c < MAXC; c++)
         if (c >= 0 && tx_tr[c] === v) return c;
      return -1;
   endfunction

   function automatic int n_strobes(input int from, input int to);
      int n = 0;
      for (int c = from; c < to && c < MAXC; c++)
         if (c >= 0 && rdb_tr[c] === 1'b0) n++;
      return n;
   endfunction

   function automatic int n_busy_low(input int from, input int to);
      int n = 0;
      for (int c = from; c < to && c < MAXC; c++)
         if (c >= 0 && busy_tr[c] !== 1'b1) n++;
      return n;
   endfunction

   task automatic push_wait(input logic [7:0] d, output int n);
      @(negedge clk);
      fall_cyc = -1;
      fifo_q.push_back(d);
      repeat (2) @(negedge clk);
      n = fall_cyc;
   endtask

   task automatic test_reset();
      int base, k;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.TX); end
      checks++; if (bus.FIFO_RDB !== 1'b1) begin errors++; $display("FAIL reset_rdb: got %b want 1", bus.FIFO_RDB); end
      checks++; if (bus.TX_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.TX_BUSY); end
      rst_n = 1'b1;
      base = cyc;
      repeat (1000) @(negedge clk);
      k = n_strobes(base, cyc);
      checks++; if (k !== 0) begin errors++; $display("FAIL idle_no_strobe: got %0d strobes want 0", k); end
      k = n_busy_low(base, cyc);
      checks++; if (k !== cyc - base) begin errors++; $display("FAIL idle_busy: busy-low cycles %0d want %0d", k, cyc - base); end
      checks++; if (find_tx(base, cyc, 1'b0) !== -1) begin errors++; $display("FAIL idle_tx: TX low while FIFO empty"); end
   endtask

   task automatic test_8n1();
      int n, s, k;
      bus.BIT8 = 1'b1; bus.PARITY_EN = 1'b0; bus.ODD_N_EVEN = 1'b0;
      push_wait(8'h55, n);
      model_frame(8'h55, 1'b1, 1'b0, 1'b0);
      repeat (175) @(negedge clk);
      k = n_strobes(n, cyc);
      checks++; if (k !== 1 || rdb_tr[n+1] !== 1'b0) begin errors++; $display("FAIL 8n1_strobe: count %0d rdb@n+1 %b want 1 and 0", k, rdb_tr[n+1]); end
      s = find_tx(n, n + 40, 1'b0);
      checks++; if (s !== n + 3) begin errors++; $display("FAIL 8n1_start: start at %0d want %0d", s, n + 3); end
      k = frame_err(s, 16, 0);
      checks++; if (k !== -1) begin errors++; $display("FAIL 8n1_bits: bit %0d differs, want all 10 bits of 0x55", k); end
      checks++; if (busy_tr[n+1] !== 1'b1 || busy_tr[s+159] !== 1'b1 || busy_tr[s+160] !== 1'b0) begin
         errors++; $display("FAIL 8n1_busy: got %b%b%b want 110", busy_tr[n+1], busy_tr[s+159], busy_tr[s+160]);
      end
      checks++; if (find_tx(s + 160, cyc, 1'b0) !== -1) begin errors++; $display("FAIL 8n1_idle: TX low after stop"); end
   endtask

   task automatic test_parity();
      int n, s, k, len;
      for (int odd = 0; odd < 2; odd++) begin
         bus.BIT8 = 1'b1; bus.PARITY_EN = 1'b1; bus.ODD_N_EVEN = odd[0];
         push_wait(8'hA5, n);
         model_frame(8'hA5, 1'b1, 1'b1, odd[0]);
         repeat (30) @(negedge clk);
         bus.BIT8 = 1'b0; bus.PARITY_EN = 1'b0; bus.ODD_N_EVEN = ~odd[0];
         repeat (170) @(negedge clk);
         len = PAR_BUILT ? 176 : 160;
         s = find_tx(n, n + 40, 1'b0);
         checks++; if (s !== n + 3) begin errors++; $display("FAIL par%0d_start: start at %0d want %0d", odd, s, n + 3); end
         k = frame_err(s, 16, 0);
         checks++; if (k !== -1) begin errors++; $display("FAIL par%0d_bits: bit %0d differs from model", odd, k); end
         checks++; if (busy_tr[s+len-1] !== 1'b1 || busy_tr[s+len] !== 1'b0) begin
            errors++; $display("FAIL par%0d_len: busy %b%b at end, want 10 for %0d-cycle frame", odd, busy_tr[s+len-1], busy_tr[s+len], len);
         end
         if (PAR_BUILT) begin
            checks++; if (tx_tr[s+9*16+8] !== odd[0]) begin errors++; $display("FAIL par%0d_bit: got %b want %0d", odd, tx_tr[s+9*16+8], odd); end
         end
      end
   endtask

   task automatic test_7bit();
      int n, s, k, len;
      bus.BIT8 = 1'b0; bus.PARITY_EN = 1'b1; bus.ODD_N_EVEN = 1'b0;
      push_wait(8'hFF, n);
      model_frame(8'hFF, 1'b0, 1'b1, 1'b0);
      repeat (180) @(negedge clk);
      len = PAR_BUILT ? 160 : 144;
      s = find_tx(n, n + 40, 1'b0);
      k = frame_err(s, 16, 0);
      checks++; if (k !== -1) begin errors++; $display("FAIL 7bit_bits: bit %0d differs from model", k); end
      checks++; if (busy_tr[s+len-1] !== 1'b1 || busy_tr[s+len] !== 1'b0) begin
         errors++; $display("FAIL 7bit_len: busy %b%b at end, want 10 for %0d-cycle frame", busy_tr[s+len-1], busy_tr[s+len], len);
      end
      bus.BIT8 = 1'b1; bus.PARITY_EN = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] data [3];
      int n, s, k, exp_s;
      data[0] = 8'h01; data[1] = 8'h80; data[2] = 8'hFF;
      bus.BIT8 = 1'b1; bus.PARITY_EN = 1'b0; bus.ODD_N_EVEN = 1'b0;
      @(negedge clk);
      fall_cyc = -1;
      for (int i = 0; i < 3; i++) fifo_q.push_back(data[i]);
      repeat (2) @(negedge clk);
      n = fall_cyc;
      repeat (3 * 163 + 20) @(negedge clk);
      k = n_strobes(n, cyc);
      checks++; if (k !== 3) begin errors++; $display("FAIL b2b_strobes: got %0d want 3", k); end
      exp_s = n + 3;
      for (int i = 0; i < 3; i++) begin
         s = find_tx((i == 0) ? n : exp_s - 163 + 160, exp_s + 20, 1'b0);
         checks++; if (s !== exp_s) begin errors++; $display("FAIL b2b_start%0d: start at %0d want %0d", i, s, exp_s); end
         model_frame(data[i], 1'b1, 1'b0, 1'b0);
         k = frame_err(exp_s, 16, 0);
         checks++; if (k !== -1) begin errors++; $display("FAIL b2b_bits%0d: bit %0d differs for byte %h", i, k, data[i]); end
         exp_s = exp_s + 163;
      end
      k = n_busy_low(n + 1, n + 3 + 2 * 163 + 160);
      checks++; if (k !== 2) begin errors++; $display("FAIL b2b_busy: busy-low cycles %0d want 2", k); end
   endtask

   task automatic test_mid_reset();
      int n, s, k, base, target;
      bus.BIT8 = 1'b1; bus.PARITY_EN = 1'b0; bus.ODD_N_EVEN = 1'b0;
      push_wait(8'hA3, n);
      target = n + 3 + 16 * 5 + 8;
      for (int i = 0; i < 200 && cyc < target; i++) @(negedge clk);
      checks++; if (bus.TX !== 1'b0) begin errors++; $display("FAIL mid_bit4: got %b want 0", bus.TX); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.TX !== 1'b1 || bus.TX_BUSY !== 1'b0) begin errors++; $display("FAIL mid_async: tx %b busy %b want 1 0", bus.TX, bus.TX_BUSY); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      base = cyc;
      repeat (40) @(negedge clk);
      checks++; if (n_strobes(base, cyc) !== 0 || find_tx(base, cyc, 1'b0) !== -1) begin
         errors++; $display("FAIL mid_no_resend: strobes %0d after reset, want 0 and TX idle", n_strobes(base, cyc));
      end
      push_wait(8'h3C, n);
      model_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      repeat (175) @(negedge clk);
      s = find_tx(n, n + 40, 1'b0);
      k = frame_err(s, 16, 0);
      checks++; if (s !== n + 3 || k !== -1) begin errors++; $display("FAIL mid_next: start %0d want %0d, bad bit %0d", s, n + 3, k); end
      checks++; if (n_strobes(base, cyc) !== 1) begin errors++; $display("FAIL mid_strobes: got %0d want 1", n_strobes(base, cyc)); end
   endtask

   task automatic test_sparse_tick();
      int n, s, r1, k;
      bus.BIT8 = 1'b1; bus.PARITY_EN = 1'b0; bus.ODD_N_EVEN = 1'b0;
      sparse = 1'b1;
      repeat (3) @(negedge clk);
      push_wait(8'h55, n);
      model_frame(8'h55, 1'b1, 1'b0, 1'b0);
      repeat (900) @(negedge clk);
      s  = find_tx(n, n + 40, 1'b0);
      r1 = find_tx(s + 1, s + 200, 1'b1);
      checks++; if (s !== n + 3) begin errors++; $display("FAIL sparse_start: start at %0d want %0d", s, n + 3); end
      checks++; if (r1 - s < 76 || r1 - s > 80) begin errors++; $display("FAIL sparse_startlen: start bit %0d cycles want 76..80", r1 - s); end
      k = frame_err(r1 - 80, 80, 1);
      checks++; if (k !== -1) begin errors++; $display("FAIL sparse_bits: bit %0d not 80 cycles of model value", k); end
      sparse = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_random();
      int n, s, k, len;
      logic [7:0] d;
      bit b8, pe, odd;
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom); b8 = 1'($urandom); pe = 1'($urandom); odd = 1'($urandom);
         bus.BIT8 = b8; bus.PARITY_EN = pe; bus.ODD_N_EVEN = odd;
         push_wait(d, n);
         model_frame(d, b8, pe, odd);
         repeat (30) @(negedge clk);
         bus.BIT8 = ~b8; bus.PARITY_EN = ~pe; bus.ODD_N_EVEN = ~odd;
         repeat (170) @(negedge clk);
         len = exp_bits.size() * 16;
         s = find_tx(n, n + 40, 1'b0);
         k = frame_err(s, 16, 0);
         checks++; if (s !== n + 3 || k !== -1) begin
            errors++; $display("FAIL rand%0d: d=%h b8=%b pe=%b odd=%b start %0d want %0d bad bit %0d", i, d, b8, pe, odd, s, n + 3, k);
         end
         checks++; if (busy_tr[s+len-1] !== 1'b1 || busy_tr[s+len] !== 1'b0) begin
            errors++; $display("FAIL rand%0d_len: busy %b%b want 10 at %0d cycles", i, busy_tr[s+len-1], busy_tr[s+len], len);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.BIT8 = 1'b1; bus.PARITY_EN = 1'b0; bus.ODD_N_EVEN = 1'b0;
      test_reset();
      test_8n1();
      test_parity();
      test_7bit();
      test_back_to_back();
      test_mid_reset();
      test_sparse_tick();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
